ram_port_master: RTL

RAM_PORT_MASTER -- requirements
Module: ram_port_master

---
 rtl/ram_pkg.sv | 7 +
 rtl/ram_port_master_if.sv | 22 ++
 rtl/ram_rd_skid.sv | 36 +++
 rtl/ram_port_master.sv | 83 ++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared RAM bank geometry, default word width and master FSM state encoding.
package ram_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int BANK_ADDR_WIDTH [4] = '{10, 12, 12, 7};
  localparam int BANK_HEIGHT [4] = '{918, 2500, 2500, 69};
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_FINISH} state_e;
endpackage

// File: rtl/ram_port_master_if.sv
// ram_port_master_if: command, write-stream, read-stream and status bundle of the RAM port master.
interface ram_port_master_if import ram_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = BANK_ADDR_WIDTH[1]
);
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_base;
  logic [ADDRESS_WIDTH:0] cmd_count;
  logic [DATA_WIDTH-1:0] s_data;
  logic s_valid, s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_valid, m_ready;
  logic done, error, busy;
  modport master (
    input cmd_valid, cmd_write, cmd_base, cmd_count, s_data, s_valid, m_ready,
    output cmd_ready, s_ready, m_data, m_valid, done, error, busy
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_count, s_data, s_valid, m_ready,
    input cmd_ready, s_ready, m_data, m_valid, done, error, busy
  );
endinterface

// File: rtl/ram_rd_skid.sv
// ram_rd_skid: two-entry FIFO holding read data until the consumer takes it.
module ram_rd_skid import ram_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [1:0] occupancy
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout = mem[rp];
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign occupancy = cnt;
endmodule

// File: rtl/ram_port_master.sv
// ram_port_master: burst read/write master for one RAM port; RAM_PORT_MASTER_BOUNDS_EN rejects bursts past ADDRESS_HEIGHT.
module ram_port_master import ram_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = BANK_ADDR_WIDTH[1],
  parameter int ADDRESS_HEIGHT = BANK_HEIGHT[1]
) (
  input  logic clk,
  input  logic rst,
  ram_port_master_if.master bus,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_write,
  output logic WR_signal,
  input  logic [DATA_WIDTH-1:0] data_read
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] READ = ST_READ;
  localparam logic [1:0] WRITE = ST_WRITE;
  localparam logic [1:0] FINISH = ST_FINISH;
`ifdef RAM_PORT_MASTER_BOUNDS_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif
  logic [1:0] state, occ;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [ADDRESS_WIDTH:0] cnt, idx, pops;
  logic [ADDRESS_WIDTH+1:0] span;
  logic rd_inf, err_q, acc, oob, skip, issue, pop, full, empty;
  assign acc = bus.cmd_valid && bus.cmd_ready;
  assign span = {2'b0, bus.cmd_base} + {1'b0, bus.cmd_count};
  assign oob = BOUNDS_EN && span > (ADDRESS_WIDTH+2)'(ADDRESS_HEIGHT);
  assign skip = bus.cmd_count == '0 || oob;
  assign pop = bus.m_valid && bus.m_ready;
  // First read goes out in the accept cycle; a same-cycle pop frees a slot for the next issue.
  assign issue = state == IDLE ? acc && !bus.cmd_write && !skip
               : state == READ && idx < cnt && !(full && !pop) && (pop || occ + {1'b0, rd_inf} < 2'd2);
  assign bus.cmd_ready = state == IDLE;
  assign bus.s_ready = state == WRITE && idx < cnt;
  assign bus.m_valid = !empty;
  assign bus.busy = state != IDLE;
  assign bus.done = state == FINISH;
  assign bus.error = bus.done && err_q;
  assign WR_signal = !rst && bus.s_valid && bus.s_ready;
  assign data_write = state == WRITE ? bus.s_data : '0;
  assign address = state == IDLE ? (acc ? bus.cmd_base : '0) : base + idx[ADDRESS_WIDTH-1:0];
  ram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) skid (
    .clk(clk), .rst(rst), .push(rd_inf), .pop(pop), .din(data_read),
    .dout(bus.m_data), .full(full), .empty(empty), .occupancy(occ)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
      cnt <= '0;
      idx <= '0;
      pops <= '0;
      rd_inf <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rd_inf <= issue;
      if (state == IDLE && acc) begin
        base <= bus.cmd_base;
        cnt <= bus.cmd_count;
        idx <= {{ADDRESS_WIDTH{1'b0}}, issue};
        pops <= '0;
        err_q <= oob;
        state <= skip ? FINISH : bus.cmd_write ? WRITE : READ;
      end
      if (state == WRITE && WR_signal) begin
        idx <= idx + 1'b1;
        if (idx + 1'b1 == cnt) state <= FINISH;
      end
      if (state == READ) begin
        if (issue) idx <= idx + 1'b1;
        if (pop) begin
          pops <= pops + 1'b1;
          if (pops + 1'b1 == cnt) state <= FINISH;
        end
      end
      if (state == FINISH) state <= IDLE;
    end
  end
endmodule
